poly_pointwise_mont: RTL and testbench
======================================

POLY_POINTWISE_MONT -- requirements
Module: poly_pointwise_mont

Interface
REQ-001 Parameter N, default 256: coefficients per polynomial.
REQ-002 Parameter Q, default 8380417: ML-DSA modulus.
REQ-003 Parameter QINV, default 58728449: Q^-1 mod 2^32.
REQ-004 i_clk  input  1  single clock; all state updates on rising edge.
REQ-005 i_rst  input  1  synchronous, active-high reset.
REQ-006 i_load  input  1  operand-B write strobe; one coefficient per high cycle.
REQ-007 i_b_data  input  32  operand-B coefficient, signed, |b| < Q.
REQ-008 i_valid  input  1  operand-A strobe from upstream NTT o_valid; no backpressure.
REQ-009 i_data  input  32  operand-A coefficient, signed, |a| < Q, taken from NTT o_data.
REQ-010 o_b_full  output  1  high when all N B coefficients are stored.
REQ-011 o_busy  output  1  high in LOAD or MUL state.
REQ-012 o_valid  output  1  result strobe, one per accepted A coefficient.
REQ-013 o_data  output  32  signed Montgomery product, in (-Q, Q).
REQ-014 o_done  output  1  one-cycle pulse coincident with the N-th o_valid of a polynomial.

Function
REQ-015 The block SHALL implement FSM states EMPTY, LOAD, READY, MUL, with an 8-bit index counter idx (log2 N bits).
REQ-016 The block SHALL hold B in an N x 32 internal buffer written at address idx.
REQ-017 EMPTY or READY with i_load=1 SHALL write i_b_data at index 0, set idx=1, and enter LOAD.
REQ-018 LOAD with i_load=1 SHALL write at idx and increment idx; i_load=0 SHALL hold (gaps allowed).
REQ-019 The write at idx=N-1 SHALL wrap idx to 0, enter READY, and set o_b_full=1 on the next cycle.
REQ-020 READY with i_valid=1 (and i_load=0) SHALL accept A[0] at index 0, set idx=1, and enter MUL.
REQ-021 MUL with i_valid=1 SHALL accept A[idx] paired with B[idx]; i_valid=0 SHALL hold idx.
REQ-022 Acceptance at idx=N-1 SHALL wrap idx to 0 and return to READY, retaining B for the next polynomial.
REQ-023 i_valid in EMPTY or LOAD, and i_load in MUL, SHALL be ignored with no state change.
REQ-024 In READY, simultaneous i_load and i_valid SHALL give i_load priority; the A coefficient is dropped.
REQ-025 A new i_load in READY SHALL clear o_b_full in the same transition.
REQ-026 Arithmetic: p = a*b as 64-bit signed; t = low 32 bits of p*QINV, signed; r = (p - t*Q) >> 32, arithmetic shift.
REQ-027 Latency SHALL be exactly 3 cycles from accept edge to o_valid, with stages: B read/product, t, r.
REQ-028 Throughput SHALL be one coefficient per cycle; outputs SHALL be in acceptance order.
REQ-029 The pipeline SHALL drain independently of the FSM, so a new polynomial may start in READY while the previous polynomial's last results are still in flight.
REQ-030 o_done SHALL be carried down the pipeline alongside the idx=N-1 acceptance.
REQ-031 o_data SHALL hold its last value when o_valid=0.

Reset
REQ-032 i_rst=1 SHALL force: state EMPTY, idx=0, o_b_full=0, o_busy=0, o_valid=0, o_done=0, o_data=0, pipeline valid bits cleared.
REQ-033 Reset mid-LOAD or mid-MUL SHALL discard the operation; no o_valid may follow the reset edge.
REQ-034 The B buffer contents need not be cleared; B SHALL be reloaded before further MUL.

Verification
REQ-035 Load B[i]=1 for all i, stream A[i]=1 for all i -> 256 outputs, each -114592, exactly 3 cycles after each accept; o_done on the 256th.
REQ-036 Load B[i]=4193792 (2^32 mod Q), stream A[i]=i -> each o_data congruent to i mod Q and within (-Q, Q); A=0 gives 0.
REQ-037 Load B with i_load gaps, then stream A with i_valid gaps -> results match the software reference pointwise_montgomery; idx holds through gaps.
REQ-038 Two back-to-back polynomials with no idle cycle, B loaded once -> 512 outputs in order, two o_done pulses.
REQ-039 i_valid before o_b_full, and i_load+i_valid together in READY -> A ignored, no o_valid, FSM enters LOAD.
REQ-040 Assert i_rst at MUL index 100 -> next cycle all outputs 0 and state EMPTY; a later full load and multiply completes correctly.

Source files
------------

// File: rtl/poly_pointwise_mont_if.sv
// Coefficient streams and status for the pointwise Montgomery multiplier.
// The B-load strobe and the A strobe carry no backpressure: a high strobe is taken or ignored in that cycle.
interface poly_pointwise_mont_if;
  logic        i_load;
  logic [31:0] i_b_data;
  logic        i_valid;
  logic [31:0] i_data;
  logic        o_b_full;
  logic        o_busy;
  logic        o_valid;
  logic [31:0] o_data;
  logic        o_done;

  modport slave (
    input  i_load, i_b_data, i_valid, i_data,
    output o_b_full, o_busy, o_valid, o_data, o_done
  );

  modport master (
    output i_load, i_b_data, i_valid, i_data,
    input  o_b_full, o_busy, o_valid, o_data, o_done
  );
endinterface

// File: rtl/poly_pointwise_mont.sv
// Pointwise a*b*2^-32 mod Q over N-coefficient polynomials. B is buffered once;
// A streams in and each product leaves through a three-stage Montgomery pipeline.
module poly_pointwise_mont #(
  parameter int N    = 256,
  parameter int Q    = 8380417,
  parameter int QINV = 58728449
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  poly_pointwise_mont_if.slave bus,
  output logic [1:0]           o_state,
  output logic [$clog2(N)-1:0] o_idx
);
  localparam int IW = $clog2(N);
  localparam logic [IW-1:0] LAST   = IW'(N - 1);
  localparam logic [31:0]   QINV32 = 32'(QINV);
  localparam logic [63:0]   Q64    = 64'(Q);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_LOAD  = 2'd1,
    S_READY = 2'd2,
    S_MUL   = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            b_we, accept, last;
  logic [31:0]     b_mem [N];

  logic [63:0]     a_ext, b_ext, p_d, p1_q, tq_full;
  logic [31:0]     t_d, t_q, p2_hi_q, tq_hi, tq_lo_unused, r_d;
  logic            v1_q, v2_q, d1_q, d2_q;
  logic            o_valid_q, o_done_q;
  logic [31:0]     o_data_q;

  // idx is always 0 in EMPTY and READY, so idx_q is the write/read address in every state.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    b_we    = 1'b0;
    accept  = 1'b0;
    last    = 1'b0;
    case (state_q)
      S_EMPTY: begin
        if (bus.i_load) begin
          b_we    = 1'b1;
          idx_d   = IW'(1);
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (bus.i_load) begin
          b_we = 1'b1;
          if (idx_q == LAST) begin
            idx_d   = '0;
            state_d = S_READY;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      S_READY: begin
        if (bus.i_load) begin
          b_we    = 1'b1;
          idx_d   = IW'(1);
          state_d = S_LOAD;
        end else if (bus.i_valid) begin
          accept  = 1'b1;
          idx_d   = IW'(1);
          state_d = S_MUL;
        end
      end
      S_MUL: begin
        if (bus.i_valid) begin
          accept = 1'b1;
          if (idx_q == LAST) begin
            idx_d   = '0;
            last    = 1'b1;
            state_d = S_READY;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = S_EMPTY;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_EMPTY;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (b_we) b_mem[idx_q] <= bus.i_b_data;
  end

  // The low words of p and t*Q cancel exactly, so only the high words need subtracting.
  always_comb begin
    a_ext = {{32{bus.i_data[31]}}, bus.i_data};
    b_ext = {{32{b_mem[idx_q][31]}}, b_mem[idx_q]};
    p_d   = a_ext * b_ext;
    t_d   = p1_q[31:0] * QINV32;
    tq_full = {{32{t_q[31]}}, t_q} * Q64;
    {tq_hi, tq_lo_unused} = tq_full;
    r_d   = p2_hi_q - tq_hi;
  end

  always_ff @(posedge i_clk) begin
    if (accept) p1_q <= p_d;
    if (v1_q) begin
      t_q     <= t_d;
      p2_hi_q <= p1_q[63:32];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      v1_q      <= 1'b0;
      v2_q      <= 1'b0;
      d1_q      <= 1'b0;
      d2_q      <= 1'b0;
      o_valid_q <= 1'b0;
      o_done_q  <= 1'b0;
      o_data_q  <= '0;
    end else begin
      v1_q      <= accept;
      d1_q      <= last;
      v2_q      <= v1_q;
      d2_q      <= d1_q;
      o_valid_q <= v2_q;
      o_done_q  <= d2_q;
      if (v2_q) o_data_q <= r_d;
    end
  end

  assign bus.o_valid  = o_valid_q;
  assign bus.o_done   = o_done_q;
  assign bus.o_data   = o_data_q;
  assign bus.o_b_full = (state_q == S_READY) || (state_q == S_MUL);
  assign bus.o_busy   = (state_q == S_LOAD) || (state_q == S_MUL);
  assign o_state      = state_q;
  assign o_idx        = idx_q;
endmodule

// File: tb/tb_poly_pointwise_mont.sv
// Directed bench for poly_pointwise_mont: B loads, A streams, ignored strobes,
// back-to-back polynomials and mid-multiply reset, checked against an output queue.
module tb_poly_pointwise_mont;
  localparam int N    = 256;
  localparam int Q    = 8380417;
  localparam int QINV = 58728449;
  localparam int R2   = 4193792;

  // ---------------- clock / reset ----------------
  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1;
  logic [1:0] st;
  logic [7:0] idx;

  always #5 i_clk = ~i_clk;

  poly_pointwise_mont_if bus();

  poly_pointwise_mont #(.N(N), .Q(Q), .QINV(QINV)) dut (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .bus    (bus),
    .o_state(st),
    .o_idx  (idx)
  );

  // ---------------- scoreboard state ----------------
  int          pass_cnt  = 0;
  int          total_cnt = 0;
  logic [31:0] exp_q[$];
  int          kind_q[$];
  bit          done_q[$];
  time         due_q[$];
  int          b_ref[N];
  time         t_edge;
  logic [31:0] last_data;
  int          rr;

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  function automatic int mont(input int a, input int b);
    longint p, m, r;
    int t;
    p = longint'(a) * longint'(b);
    m = p * longint'(QINV);
    t = int'(m);
    r = (p - longint'(t) * longint'(Q)) >>> 32;
    return int'(r);
  endfunction

  function automatic int rnd_coef();
    return int'($urandom_range(2 * Q - 2, 0)) - (Q - 1);
  endfunction

  function automatic void flush();
    exp_q.delete();
    kind_q.delete();
    done_q.delete();
    due_q.delete();
  endfunction

  // Output monitor: kind 0 = exact value, kind 1 = congruent to the stored value mod Q.
  always @(negedge i_clk) begin
    if (i_rst) begin
      last_data = '0;
    end else begin
      while (due_q.size() > 0 && due_q[0] < $time) begin
        chk("missing_valid", 0, 1);
        void'(exp_q.pop_front());
        void'(kind_q.pop_front());
        void'(done_q.pop_front());
        void'(due_q.pop_front());
      end
      if (bus.o_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_valid", 1, 0);
        end else begin
          chk("latency", $time, due_q[0]);
          if (kind_q[0] == 0) begin
            chk("data", $signed(bus.o_data), $signed(exp_q[0]));
          end else begin
            rr = $signed(bus.o_data);
            chk("congruence", ((rr - int'(exp_q[0])) % Q + Q) % Q, 0);
            chk("range", (rr > -Q && rr < Q), 1);
          end
          chk("done", bus.o_done, done_q[0]);
          void'(exp_q.pop_front());
          void'(kind_q.pop_front());
          void'(done_q.pop_front());
          void'(due_q.pop_front());
        end
        last_data = bus.o_data;
      end else begin
        chk("hold", bus.o_data, last_data);
        chk("spurious_done", bus.o_done, 0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge i_clk);
    t_edge = $time;
    #1;
  endtask

  task automatic push(input logic [31:0] v, input int k, input bit d);
    exp_q.push_back(v);
    kind_q.push_back(k);
    done_q.push_back(d);
    due_q.push_back(t_edge + 25);
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    bus.i_load = 1'b0;
    tick();
    flush();
    chk("rst_valid", bus.o_valid, 0);
    chk("rst_done", bus.o_done, 0);
    chk("rst_data", bus.o_data, 0);
    chk("rst_b_full", bus.o_b_full, 0);
    chk("rst_busy", bus.o_busy, 0);
    chk("rst_state", st, 0);
    chk("rst_idx", idx, 0);
    bus.i_valid = 1'b0;
    tick();
    i_rst = 1'b0;
  endtask

  task automatic load_b(input int kind, input bit gaps, input int start);
    int v;
    for (int i = start; i < N; i++) begin
      if (gaps && i > 0 && $urandom_range(3, 0) == 0) begin
        bus.i_load  = 1'b0;
        bus.i_valid = 1'b1;
        bus.i_data  = rnd_coef();
        repeat ($urandom_range(2, 1)) tick();
        bus.i_valid = 1'b0;
        chk("load_gap_idx", idx, i);
        chk("load_gap_state", st, 1);
      end
      v = (kind == 0) ? 1 : (kind == 1) ? R2 : rnd_coef();
      b_ref[i]     = v;
      bus.i_load   = 1'b1;
      bus.i_b_data = v;
      tick();
    end
    bus.i_load = 1'b0;
    chk("load_end_state", st, 2);
    chk("load_end_b_full", bus.o_b_full, 1);
    chk("load_end_busy", bus.o_busy, 0);
    chk("load_end_idx", idx, 0);
  endtask

  task automatic stream_a(input int kind, input bit gaps, input int stop);
    int v;
    for (int i = 0; i < stop; i++) begin
      if (gaps && i > 0 && $urandom_range(3, 0) == 0) begin
        bus.i_valid  = 1'b0;
        bus.i_load   = 1'($urandom_range(1, 0));
        bus.i_b_data = rnd_coef();
        tick();
        bus.i_load = 1'b0;
        chk("mul_gap_idx", idx, i);
        chk("mul_gap_state", st, 3);
      end
      v = (kind == 0) ? 1 : (kind == 1) ? i : rnd_coef();
      bus.i_valid = 1'b1;
      bus.i_data  = v;
      tick();
      if (kind == 0)      push(-114592, 0, i == N - 1);
      else if (kind == 1) push(i, 1, i == N - 1);
      else                push(mont(v, b_ref[i]), 0, i == N - 1);
    end
  endtask

  task automatic drain();
    bus.i_valid = 1'b0;
    repeat (5) tick();
    chk("drained", exp_q.size(), 0);
    chk("drain_state", st, 2);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int v;
    bus.i_load   = 1'b0;
    bus.i_b_data = '0;
    bus.i_valid  = 1'b0;
    bus.i_data   = '0;
    do_reset();

    // A strobes before any B is loaded are ignored.
    bus.i_valid = 1'b1;
    bus.i_data  = 32'd5;
    repeat (3) tick();
    bus.i_valid = 1'b0;
    chk("empty_ignore_state", st, 0);
    chk("empty_ignore_busy", bus.o_busy, 0);

    // all-ones: each result is 2^-32 mod Q in signed form.
    load_b(0, 1'b0, 0);
    stream_a(0, 1'b0, N);
    drain();

    // B = 2^32 mod Q cancels the Montgomery factor.
    load_b(1, 1'b0, 0);
    stream_a(1, 1'b0, N);
    drain();

    // random operands with strobe gaps on both phases.
    load_b(2, 1'b1, 0);
    stream_a(2, 1'b1, N);
    drain();

    // two polynomials back to back against the same B.
    stream_a(2, 1'b0, N);
    stream_a(2, 1'b0, N);
    drain();

    // load and valid together in READY: load wins, A dropped.
    v = rnd_coef();
    b_ref[0]     = v;
    bus.i_load   = 1'b1;
    bus.i_b_data = v;
    bus.i_valid  = 1'b1;
    bus.i_data   = rnd_coef();
    tick();
    bus.i_load  = 1'b0;
    bus.i_valid = 1'b0;
    chk("prio_state", st, 1);
    chk("prio_idx", idx, 1);
    chk("prio_b_full", bus.o_b_full, 0);
    chk("prio_busy", bus.o_busy, 1);
    load_b(2, 1'b0, 1);
    stream_a(2, 1'b0, N);
    drain();

    // reset in the middle of a multiply, then a full reload and multiply.
    stream_a(2, 1'b0, 100);
    chk("pre_reset_idx", idx, 100);
    chk("pre_reset_state", st, 3);
    do_reset();
    repeat (6) tick();
    chk("post_reset_state", st, 0);
    load_b(2, 1'b1, 0);
    stream_a(2, 1'b0, N);
    drain();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
